morse_text_encoder: RTL and testbench

- Upstream feeder of the piezo playback stage. Takes ASCII characters over a valid/ready stream and converts each one to the team's Morse bitstream format.
- Builds the bitstream in a 256-bit buffer, LSB first. At end of message it hands the buffer to the player with a one-cycle start pulse, then waits for the player's done before accepting the next message.
- Bitstream format, bits consumed in order from index 0:
  - dit = "0"
  - dah = "1","0" (bit n = 1, bit n+1 = 0)
  - letter gap = "1","1"
  - word gap = "1","1","1","1"

---
 rtl/morse_text_encoder.sv | 269 ++++++++++++++++++++++++++
 tb/tb_morse_text_encoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/morse_text_encoder.sv
// ASCII-to-Morse bitstream builder feeding the piezo player.
// Characters arrive on a valid/ready stream; the finished buffer is handed off with a one-cycle start pulse.
module morse_text_encoder #(
    parameter int unsigned MAX_BITS = 256,
    parameter int unsigned LEN_W    = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          char_in,
    input  logic                char_valid,
    input  logic                char_last,
    output logic                char_ready,
    output logic [MAX_BITS-1:0] bitstream,
    output logic [LEN_W-1:0]    bit_length,
    output logic                start,
    input  logic                player_busy,
    input  logic                player_done,
    output logic                msg_active,
    output logic                err_char,
    output logic                overflow
);

    localparam int unsigned SUM_W  = LEN_W + 1;
    localparam int unsigned NEED_W = 4;

    typedef enum logic [2:0] {
        S_ACCEPT, S_LOOKUP, S_SEP, S_EMIT, S_FINISH, S_WAIT_DONE
    } state_e;

    typedef enum logic [1:0] {
        TOK_NONE, TOK_LETTER, TOK_WORDGAP
    } token_e;

    // {len[2:0], pat[4:0]}; pat is left-justified, pat[4] is the first symbol, 1 = dah. len 0 = unsupported.
    function automatic logic [7:0] morse_lut(input logic [7:0] c);
        case (c)
            "A": morse_lut = {3'd2, 5'b01000};
            "B": morse_lut = {3'd4, 5'b10000};
            "C": morse_lut = {3'd4, 5'b10100};
            "D": morse_lut = {3'd3, 5'b10000};
            "E": morse_lut = {3'd1, 5'b00000};
            "F": morse_lut = {3'd4, 5'b00100};
            "G": morse_lut = {3'd3, 5'b11000};
            "H": morse_lut = {3'd4, 5'b00000};
            "I": morse_lut = {3'd2, 5'b00000};
            "J": morse_lut = {3'd4, 5'b01110};
            "K": morse_lut = {3'd3, 5'b10100};
            "L": morse_lut = {3'd4, 5'b01000};
            "M": morse_lut = {3'd2, 5'b11000};
            "N": morse_lut = {3'd2, 5'b10000};
            "O": morse_lut = {3'd3, 5'b11100};
            "P": morse_lut = {3'd4, 5'b01100};
            "Q": morse_lut = {3'd4, 5'b11010};
            "R": morse_lut = {3'd3, 5'b01000};
            "S": morse_lut = {3'd3, 5'b00000};
            "T": morse_lut = {3'd1, 5'b10000};
            "U": morse_lut = {3'd3, 5'b00100};
            "V": morse_lut = {3'd4, 5'b00010};
            "W": morse_lut = {3'd3, 5'b01100};
            "X": morse_lut = {3'd4, 5'b10010};
            "Y": morse_lut = {3'd4, 5'b10110};
            "Z": morse_lut = {3'd4, 5'b11000};
            "0": morse_lut = {3'd5, 5'b11111};
            "1": morse_lut = {3'd5, 5'b01111};
            "2": morse_lut = {3'd5, 5'b00111};
            "3": morse_lut = {3'd5, 5'b00011};
            "4": morse_lut = {3'd5, 5'b00001};
            "5": morse_lut = {3'd5, 5'b00000};
            "6": morse_lut = {3'd5, 5'b10000};
            "7": morse_lut = {3'd5, 5'b11000};
            "8": morse_lut = {3'd5, 5'b11100};
            "9": morse_lut = {3'd5, 5'b11110};
            default: morse_lut = 8'h00;
        endcase
    endfunction

    state_e                state_q, state_d;
    token_e                prev_q, prev_d;
    logic [7:0]            char_q, char_d;
    logic                  last_q, last_d;
    logic [2:0]            sym_len_q, sym_len_d;
    logic [4:0]            sym_pat_q, sym_pat_d;
    logic [2:0]            sep_q, sep_d;
    logic                  is_space_q, is_space_d;
    logic                  char_ready_q, char_ready_d;
    logic [MAX_BITS-1:0]   bitstream_q, bitstream_d;
    logic [LEN_W-1:0]      bit_length_q, bit_length_d;
    logic                  start_q, start_d;
    logic                  msg_active_q, msg_active_d;
    logic                  err_q, err_d;
    logic                  overflow_q, overflow_d;

    logic [7:0]            upper_c;
    logic [7:0]            code_c;
    logic [2:0]            dahs_c;
    logic [2:0]            letter_sep_c;
    logic [NEED_W-1:0]     need_c;
    logic                  is_space_char_c;
    logic                  fits_c;

    // Decode of the latched character and the capacity check for it.
    always_comb begin
        upper_c = char_q;
        if (char_q >= 8'h61 && char_q <= 8'h7A) begin
            upper_c = char_q - 8'd32;
        end
        code_c = morse_lut(upper_c);
        dahs_c = '0;
        for (int i = 0; i < 5; i++) begin
            dahs_c = dahs_c + 3'(code_c[i]);
        end
        is_space_char_c = (char_q == 8'h20);
        letter_sep_c    = (prev_q == TOK_LETTER) ? 3'd2 : 3'd0;
        if (is_space_char_c) begin
            need_c = NEED_W'(4);
        end else begin
            need_c = NEED_W'(letter_sep_c) + NEED_W'(code_c[7:5]) + NEED_W'(dahs_c);
        end
        fits_c = (SUM_W'(bit_length_q) + SUM_W'(need_c)) <= SUM_W'(MAX_BITS);
    end

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        char_d       = char_q;
        last_d       = last_q;
        sym_len_d    = sym_len_q;
        sym_pat_d    = sym_pat_q;
        sep_d        = sep_q;
        is_space_d   = is_space_q;
        bitstream_d  = bitstream_q;
        bit_length_d = bit_length_q;
        msg_active_d = msg_active_q;
        overflow_d   = overflow_q;
        start_d      = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            S_ACCEPT: begin
                if (char_valid && char_ready_q) begin
                    char_d       = char_in;
                    last_d       = char_last;
                    msg_active_d = 1'b1;
                    if (!msg_active_q) begin
                        overflow_d = 1'b0;
                    end
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                // Dropped or ignored characters fall straight through to the next step.
                state_d = last_q ? S_FINISH : S_ACCEPT;
                if (is_space_char_c) begin
                    if (prev_q == TOK_LETTER) begin
                        if (fits_c) begin
                            sep_d      = 3'd4;
                            is_space_d = 1'b1;
                            state_d    = S_SEP;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end else if (code_c[7:5] == 3'd0) begin
                    err_d = 1'b1;
                end else if (fits_c) begin
                    sym_len_d  = code_c[7:5];
                    sym_pat_d  = code_c[4:0];
                    sep_d      = letter_sep_c;
                    is_space_d = 1'b0;
                    state_d    = (letter_sep_c != 3'd0) ? S_SEP : S_EMIT;
                end else begin
                    overflow_d = 1'b1;
                end
            end
            S_SEP: begin
                bitstream_d  = bitstream_q
                             | (MAX_BITS'((sep_q == 3'd4) ? 4'hF : 4'h3) << bit_length_q);
                bit_length_d = bit_length_q + LEN_W'(sep_q);
                if (is_space_q) begin
                    prev_d  = TOK_WORDGAP;
                    state_d = last_q ? S_FINISH : S_ACCEPT;
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (sym_pat_q[4]) begin
                    bitstream_d  = bitstream_q | (MAX_BITS'(1) << bit_length_q);
                    bit_length_d = bit_length_q + LEN_W'(2);
                end else begin
                    bit_length_d = bit_length_q + LEN_W'(1);
                end
                sym_pat_d = sym_pat_q << 1;
                sym_len_d = sym_len_q - 3'd1;
                if (sym_len_q == 3'd1) begin
                    prev_d  = TOK_LETTER;
                    state_d = last_q ? S_FINISH : S_ACCEPT;
                end
            end
            S_FINISH: begin
                if (bit_length_q == '0) begin
                    msg_active_d = 1'b0;
                    state_d      = S_ACCEPT;
                end else if (!player_busy) begin
                    start_d = 1'b1;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // A done coinciding with our own start pulse is stale and ignored.
                if (player_done && !start_q) begin
                    bitstream_d  = '0;
                    bit_length_d = '0;
                    prev_d       = TOK_NONE;
                    msg_active_d = 1'b0;
                    state_d      = S_ACCEPT;
                end
            end
            default: state_d = S_ACCEPT;
        endcase

        char_ready_d = (state_d == S_ACCEPT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_ACCEPT;
            prev_q       <= TOK_NONE;
            char_q       <= '0;
            last_q       <= 1'b0;
            sym_len_q    <= '0;
            sym_pat_q    <= '0;
            sep_q        <= '0;
            is_space_q   <= 1'b0;
            char_ready_q <= 1'b0;
            bitstream_q  <= '0;
            bit_length_q <= '0;
            start_q      <= 1'b0;
            msg_active_q <= 1'b0;
            err_q        <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            char_q       <= char_d;
            last_q       <= last_d;
            sym_len_q    <= sym_len_d;
            sym_pat_q    <= sym_pat_d;
            sep_q        <= sep_d;
            is_space_q   <= is_space_d;
            char_ready_q <= char_ready_d;
            bitstream_q  <= bitstream_d;
            bit_length_q <= bit_length_d;
            start_q      <= start_d;
            msg_active_q <= msg_active_d;
            err_q        <= err_d;
            overflow_q   <= overflow_d;
        end
    end

    assign char_ready = char_ready_q;
    assign bitstream  = bitstream_q;
    assign bit_length = bit_length_q;
    assign start      = start_q;
    assign msg_active = msg_active_q;
    assign err_char   = err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_morse_text_encoder.sv
// Directed bench for morse_text_encoder with hand-computed bitstreams and a stand-in player.
module tb_morse_text_encoder;

    logic         clk;
    logic         rst_n;
    logic [7:0]   char_in;
    logic         char_valid;
    logic         char_last;
    logic         char_ready;
    logic [255:0] bitstream;
    logic [8:0]   bit_length;
    logic         start;
    logic         player_busy;
    logic         player_done;
    logic         msg_active;
    logic         err_char;
    logic         overflow;

    int n_compared = 0;
    int n_mismatch = 0;
    int err_cnt    = 0;
    int start_cnt  = 0;

    morse_text_encoder #(.MAX_BITS(256), .LEN_W(9)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_last  (char_last),
        .char_ready (char_ready),
        .bitstream  (bitstream),
        .bit_length (bit_length),
        .start      (start),
        .player_busy(player_busy),
        .player_done(player_done),
        .msg_active (msg_active),
        .err_char   (err_char),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_char) err_cnt++;
        if (start) start_cnt++;
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_char(input logic [7:0] c, input logic last);
        int n;
        @(negedge clk);
        char_in    = c;
        char_last  = last;
        char_valid = 1'b1;
        n = 0;
        while (!char_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("ready_timeout", 256'(char_ready), 256'(1));
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        char_last  = 1'b0;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        @(negedge clk);
        while (!start && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check_eq("start_timeout", 256'(start), 256'(1));
    endtask

    // Player stand-in: a done in the start cycle must be ignored, a later one clears the buffer.
    task automatic finish_msg(input logic [255:0] exp_bs, input logic [8:0] exp_len);
        wait_start();
        check_eq("bitstream", bitstream, exp_bs);
        check_eq("bit_length", 256'(bit_length), 256'(exp_len));
        check_eq("msg_active_play", 256'(msg_active), 256'(1));
        player_done = 1'b1;
        @(negedge clk);
        player_done = 1'b0;
        check_eq("start_width", 256'(start), 256'(0));
        check_eq("early_done_ignored", 256'(bit_length), 256'(exp_len));
        check_eq("ready_in_wait", 256'(char_ready), 256'(0));
        @(negedge clk);
        player_done = 1'b1;
        @(negedge clk);
        player_done = 1'b0;
        check_eq("cleared_len", 256'(bit_length), 256'(0));
        check_eq("cleared_bits", bitstream, 256'(0));
        check_eq("msg_inactive", 256'(msg_active), 256'(0));
    endtask

    initial begin
        logic [255:0] exp_zeros;
        int p;
        int e0;
        int s0;
        int bad;

        rst_n       = 1'b0;
        char_in     = 8'h00;
        char_valid  = 1'b0;
        char_last   = 1'b0;
        player_busy = 1'b0;
        player_done = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 256'(char_ready), 256'(0));
        check_eq("rst_bits", bitstream, 256'(0));
        check_eq("rst_len", 256'(bit_length), 256'(0));
        check_eq("rst_flags", 256'({start, msg_active, err_char, overflow}), 256'(0));
        rst_n = 1'b1;

        // "E"
        send_char("E", 1'b1);
        finish_msg(256'h0, 9'd1);

        // "ET": 0, 11, 10
        send_char("E", 1'b0);
        send_char("T", 1'b1);
        finish_msg(256'h0E, 9'd5);

        // "E E": 0, 1111, 0
        send_char("E", 1'b0);
        send_char(" ", 1'b0);
        send_char("E", 1'b1);
        finish_msg(256'h1E, 9'd6);

        // "  A": leading spaces ignored
        send_char(" ", 1'b0);
        send_char(" ", 1'b0);
        send_char("A", 1'b1);
        finish_msg(256'h2, 9'd3);

        // "a#": lowercase folded, '#' rejected
        e0 = err_cnt;
        send_char("a", 1'b0);
        send_char("#", 1'b1);
        finish_msg(256'h2, 9'd3);
        check_eq("err_pulses", 256'(err_cnt - e0), 256'(1));

        // 22 x "0": only 21 fit (10 + 20*12 = 250 bits)
        exp_zeros = '0;
        p = 0;
        for (int i = 0; i < 21; i++) begin
            if (i > 0) begin
                exp_zeros[p] = 1'b1;
                exp_zeros[p+1] = 1'b1;
                p += 2;
            end
            for (int j = 0; j < 5; j++) begin
                exp_zeros[p] = 1'b1;
                p += 2;
            end
        end
        for (int i = 0; i < 22; i++) send_char("0", i == 21);
        finish_msg(exp_zeros, 9'd250);
        check_eq("overflow_sticky", 256'(overflow), 256'(1));

        // busy player delays start; overflow clears on the first character
        player_busy = 1'b1;
        s0 = start_cnt;
        send_char("E", 1'b1);
        check_eq("overflow_cleared", 256'(overflow), 256'(0));
        repeat (10) @(negedge clk);
        check_eq("no_start_while_busy", 256'(start_cnt - s0), 256'(0));
        check_eq("active_while_busy", 256'(msg_active), 256'(1));
        player_busy = 1'b0;
        finish_msg(256'h0, 9'd1);

        // "T" then withhold done for 100 cycles with a pending character
        send_char("T", 1'b1);
        wait_start();
        @(negedge clk);
        char_in    = "E";
        char_valid = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (char_ready || bit_length != 9'd2 || bitstream != 256'h1 || !msg_active) bad++;
        end
        check_eq("hold_stable", 256'(bad), 256'(0));

        // asynchronous reset while waiting for done
        rst_n = 1'b0;
        #1;
        check_eq("rst_wait_bits", bitstream, 256'(0));
        check_eq("rst_wait_len", 256'(bit_length), 256'(0));
        @(negedge clk);
        check_eq("rst_wait_flags", 256'({char_ready, start, msg_active, err_char, overflow}), 256'(0));
        char_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
